// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue
//   Receives decoded instructions from the decode mux. Each one is held in a
//   small in-order FIFO and handed to the functional unit named by its
//   unit-type field over a per-unit valid/ready handshake. The head entry is
//   visible combinationally (first-word fall-through). A head whose unit
//   code is not a real unit is discarded, and a one-cycle flag reports it.
//
// Ports
//   clock_i, reset_i      clock; synchronous active-high reset
//   enable_i + payload    decoded instruction present this cycle
//   stall_o               queue full, so decode must hold
//   overflow_o            sticky: an enable arrived while the queue was full
//   illegalUnit_o         pulse for one cycle after a code-5/7 head is dropped
//   dispatchValid_o[8]    one-hot valid for the unit the head entry targets
//   dispatchReady_i[8]    per-unit ready; only the selected bit matters
//   payload outputs       head entry payload, forced to 0 when empty
//   occupancy_o           current number of entries
module decode_dispatch_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 6,
  parameter int regSize                 = 5,
  parameter int immWidth                = 64,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int funcUnitCodeSize        = 3,
  parameter int queueDepth              = 4,
  parameter int FXUnitId                = 0,
  parameter int FPUnitId                = 1,
  parameter int VXUnitId                = 2,
  parameter int CRUnitId                = 3,
  parameter int LSUnitId                = 4,
  parameter int BranchUnitID            = 6
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            address_i,
  input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
  input  logic [instructionCounterWidth-1:0] majID_i,
  input  logic [instMinIdWidth-1:0]          minID_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 pid_i,
  input  logic [TidSize-1:0]                 tid_i,
  input  logic [regSize-1:0]                 op1_i,
  input  logic [regSize-1:0]                 op2_i,
  input  logic [regSize-1:0]                 op3_i,
  input  logic [regSize-1:0]                 op4_i,
  input  logic [immWidth-1:0]                imm_i,
  output logic                               stall_o,
  output logic                               overflow_o,
  output logic                               illegalUnit_o,
  output logic [7:0]                         dispatchValid_o,
  input  logic [7:0]                         dispatchReady_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            address_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [regSize-1:0]                 op1_o,
  output logic [regSize-1:0]                 op2_o,
  output logic [regSize-1:0]                 op3_o,
  output logic [regSize-1:0]                 op4_o,
  output logic [immWidth-1:0]                imm_o,
  output logic [$clog2(queueDepth):0]        occupancy_o
);

  localparam int PtrW = $clog2(queueDepth);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [opcodeSize-1:0]              opcode;
    logic [addressWidth-1:0]            address;
    logic [funcUnitCodeSize-1:0]        unit;
    logic [instructionCounterWidth-1:0] maj_id;
    logic [instMinIdWidth-1:0]          min_id;
    logic                               is_64bit;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [regSize-1:0]                 op1;
    logic [regSize-1:0]                 op2;
    logic [regSize-1:0]                 op3;
    logic [regSize-1:0]                 op4;
    logic [immWidth-1:0]                imm;
  } entry_t;

  entry_t          mem_q [queueDepth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            illegal_q, illegal_d;

  entry_t entry_in;
  entry_t head_entry;
  entry_t out_entry;
  logic   empty, full, unit_legal, push, pop;

  always_comb begin
    entry_in          = '0;
    entry_in.opcode   = opcode_i;
    entry_in.address  = address_i;
    entry_in.unit     = funcUnitType_i;
    entry_in.maj_id   = majID_i;
    entry_in.min_id   = minID_i;
    entry_in.is_64bit = is64Bit_i;
    entry_in.pid      = pid_i;
    entry_in.tid      = tid_i;
    entry_in.op1      = op1_i;
    entry_in.op2      = op2_i;
    entry_in.op3      = op3_i;
    entry_in.op4      = op4_i;
    entry_in.imm      = imm_i;
  end

  always_comb begin
    head_entry = mem_q[head_q];
    empty      = (count_q == '0);
    full       = (count_q == CntW'(queueDepth));

    unit_legal = (int'(head_entry.unit) == FXUnitId) || (int'(head_entry.unit) == FPUnitId) ||
                 (int'(head_entry.unit) == VXUnitId) || (int'(head_entry.unit) == CRUnitId) ||
                 (int'(head_entry.unit) == LSUnitId) || (int'(head_entry.unit) == BranchUnitID);

    // Full is judged from the registered count, so a pop in the same cycle
    // does not open a slot for the incoming instruction.
    push = enable_i && !full;
    // An illegal head pops unconditionally; a legal head pops only on the
    // ready bit of its own unit, and every other ready bit is ignored.
    pop  = !empty && (!unit_legal || dispatchReady_i[head_entry.unit]);

    head_d     = pop  ? head_q + PtrW'(1) : head_q;
    tail_d     = push ? tail_q + PtrW'(1) : tail_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CntW'(1);
    if (pop && !push) count_d = count_q - CntW'(1);
    overflow_d = overflow_q || (enable_i && full);
    illegal_d  = pop && !unit_legal;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  // NOTE: the payload storage has no reset; validity lives entirely in the
  // count and pointers, so stale slots are never observable.
  always_ff @(posedge clock_i) begin
    if (push && !reset_i) mem_q[tail_q] <= entry_in;
  end

  always_comb begin
    out_entry       = empty ? '0 : head_entry;
    dispatchValid_o = (!empty && unit_legal) ? (8'(1) << head_entry.unit) : 8'h00;
  end

  assign stall_o        = full;
  assign overflow_o     = overflow_q;
  assign illegalUnit_o  = illegal_q;
  assign occupancy_o    = count_q;
  assign opcode_o       = out_entry.opcode;
  assign address_o      = out_entry.address;
  assign funcUnitType_o = out_entry.unit;
  assign majID_o        = out_entry.maj_id;
  assign minID_o        = out_entry.min_id;
  assign is64Bit_o      = out_entry.is_64bit;
  assign pid_o          = out_entry.pid;
  assign tid_o          = out_entry.tid;
  assign op1_o          = out_entry.op1;
  assign op2_o          = out_entry.op2;
  assign op3_o          = out_entry.op3;
  assign op4_o          = out_entry.op4;
  assign imm_o          = out_entry.imm;

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Testbench for decode_dispatch_queue: a table of per-cycle vectors covers
// basic dispatch, fill/overflow/drain, head-of-line blocking and illegal
// codes; hand-written sequences cover push+pop wrap, payload pass-through
// and reset. Inputs change at negedge; outputs are sampled 1 ns later.
module tb_decode_dispatch_queue;

  logic        clk = 1'b0;
  logic        reset_i, enable_i;
  logic [5:0]  opcode_i, opcode_o;
  logic [63:0] address_i, address_o;
  logic [2:0]  unit_i, unit_o;
  logic [63:0] maj_i, maj_o;
  logic [6:0]  min_i, min_o;
  logic        is64_i, is64_o;
  logic [19:0] pid_i, pid_o;
  logic [15:0] tid_i, tid_o;
  logic [4:0]  op1_i, op2_i, op3_i, op4_i, op1_o, op2_o, op3_o, op4_o;
  logic [63:0] imm_i, imm_o;
  logic        stall_o, overflow_o, illegal_o;
  logic [7:0]  valid_o, ready_i;
  logic [2:0]  occ_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_dispatch_queue dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(unit_i),
    .majID_i(maj_i), .minID_i(min_i), .is64Bit_i(is64_i), .pid_i(pid_i),
    .tid_i(tid_i), .op1_i(op1_i), .op2_i(op2_i), .op3_i(op3_i), .op4_i(op4_i),
    .imm_i(imm_i), .stall_o(stall_o), .overflow_o(overflow_o),
    .illegalUnit_o(illegal_o), .dispatchValid_o(valid_o),
    .dispatchReady_i(ready_i), .opcode_o(opcode_o), .address_o(address_o),
    .funcUnitType_o(unit_o), .majID_o(maj_o), .minID_o(min_o),
    .is64Bit_o(is64_o), .pid_o(pid_o), .tid_o(tid_o), .op1_o(op1_o),
    .op2_o(op2_o), .op3_o(op3_o), .op4_o(op4_o), .imm_o(imm_o),
    .occupancy_o(occ_o)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One row = inputs held for one cycle, plus the outputs expected while
  // those inputs are applied (i.e. from the state before the next edge).
  typedef struct {
    logic        en;
    logic [2:0]  unit;
    logic [63:0] maj;
    logic [7:0]  rdy;
    logic [7:0]  e_valid;
    int          e_occ;
    logic        e_stall;
    logic        e_ovf;
    logic        e_ill;
    logic [63:0] e_maj;
  } vec_t;

  function automatic vec_t mk(logic en, logic [2:0] unit, logic [63:0] maj, logic [7:0] rdy,
                              logic [7:0] ev, int eocc, logic est, logic eovf, logic eill,
                              logic [63:0] emaj);
    vec_t v;
    v.en = en; v.unit = unit; v.maj = maj; v.rdy = rdy;
    v.e_valid = ev; v.e_occ = eocc; v.e_stall = est; v.e_ovf = eovf;
    v.e_ill = eill; v.e_maj = emaj;
    return v;
  endfunction

  // Opcode travels with the majID so the table also checks opcode routing
  // (majID 5 carries opcode 31).
  function automatic logic [5:0] op_of(logic [63:0] maj);
    logic [5:0] m;
    m = maj[5:0];
    return m + 6'd26;
  endfunction

  task automatic drive(logic en, logic [2:0] unit, logic [63:0] maj, logic [7:0] rdy);
    enable_i  = en;
    unit_i    = unit;
    maj_i     = maj;
    opcode_i  = op_of(maj);
    ready_i   = rdy;
    address_i = '0; min_i = '0; is64_i = 1'b0; pid_i = '0; tid_i = '0;
    op1_i = '0; op2_i = '0; op3_i = '0; op4_i = '0; imm_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  vec_t vecs[25];
  logic [63:0] exp_q[$];
  logic [63:0] exp_maj;

  initial begin
    // basic FX dispatch
    vecs[0]  = mk(1, 0, 5,  8'h00, 8'h00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,  8'h00, 8'h01, 1, 0, 0, 0, 5);
    vecs[2]  = mk(0, 0, 0,  8'h01, 8'h01, 1, 0, 0, 0, 5);
    vecs[3]  = mk(0, 0, 0,  8'h00, 8'h00, 0, 0, 0, 0, 0);
    // fill to 4, overflow on the 5th, drain in order
    vecs[4]  = mk(1, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 2,  8'h00, 8'h01, 1, 0, 0, 0, 1);
    vecs[6]  = mk(1, 0, 3,  8'h00, 8'h01, 2, 0, 0, 0, 1);
    vecs[7]  = mk(1, 0, 4,  8'h00, 8'h01, 3, 0, 0, 0, 1);
    vecs[8]  = mk(1, 0, 9,  8'h00, 8'h01, 4, 1, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0,  8'hFF, 8'h01, 4, 1, 1, 0, 1);
    vecs[10] = mk(0, 0, 0,  8'hFF, 8'h01, 3, 0, 1, 0, 2);
    vecs[11] = mk(0, 0, 0,  8'hFF, 8'h01, 2, 0, 1, 0, 3);
    vecs[12] = mk(0, 0, 0,  8'hFF, 8'h01, 1, 0, 1, 0, 4);
    vecs[13] = mk(0, 0, 0,  8'h00, 8'h00, 0, 0, 1, 0, 0);
    // LS head blocks a younger FX entry even though FX is ready
    vecs[14] = mk(1, 4, 10, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    vecs[15] = mk(1, 0, 11, 8'h01, 8'h10, 1, 0, 1, 0, 10);
    vecs[16] = mk(0, 0, 0,  8'h01, 8'h10, 2, 0, 1, 0, 10);
    vecs[17] = mk(0, 0, 0,  8'h10, 8'h10, 2, 0, 1, 0, 10);
    vecs[18] = mk(0, 0, 0,  8'h01, 8'h01, 1, 0, 1, 0, 11);
    vecs[19] = mk(0, 0, 0,  8'h00, 8'h00, 0, 0, 1, 0, 0);
    // unit code 5 is dropped without ready, then a VX entry dispatches
    vecs[20] = mk(1, 5, 20, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    vecs[21] = mk(1, 2, 21, 8'h00, 8'h00, 1, 0, 1, 0, 20);
    vecs[22] = mk(0, 0, 0,  8'h00, 8'h04, 1, 0, 1, 1, 21);
    vecs[23] = mk(0, 0, 0,  8'h04, 8'h04, 1, 0, 1, 0, 21);
    vecs[24] = mk(0, 0, 0,  8'h00, 8'h00, 0, 0, 1, 0, 0);

    reset_i = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 8'h00);
    @(negedge clk);
    do_reset();
    #1;
    check("reset occ",   64'(occ_o),      64'd0);
    check("reset stall", 64'(stall_o),    64'd0);
    check("reset valid", 64'(valid_o),    64'd0);
    check("reset ovf",   64'(overflow_o), 64'd0);
    check("reset maj",   maj_o,           64'd0);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].en, vecs[i].unit, vecs[i].maj, vecs[i].rdy);
      #1;
      check($sformatf("v%0d valid", i), 64'(valid_o), 64'(vecs[i].e_valid));
      check($sformatf("v%0d occ", i), 64'(occ_o), 64'(vecs[i].e_occ));
      check($sformatf("v%0d stall", i), 64'(stall_o), 64'(vecs[i].e_stall));
      check($sformatf("v%0d ovf", i), 64'(overflow_o), 64'(vecs[i].e_ovf));
      check($sformatf("v%0d illegal", i), 64'(illegal_o), 64'(vecs[i].e_ill));
      check($sformatf("v%0d maj", i), maj_o, vecs[i].e_maj);
      check($sformatf("v%0d opcode", i), 64'(opcode_o),
            (vecs[i].e_maj == 0) ? 64'd0 : 64'(op_of(vecs[i].e_maj)));
      @(negedge clk);
    end

    // Unit code 7 is also illegal.
    do_reset();
    drive(1'b1, 3'd7, 64'd40, 8'hFF);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'hFF);
    #1;
    check("code7 valid", 64'(valid_o), 64'd0);
    check("code7 occ",   64'(occ_o),   64'd1);
    @(negedge clk);
    #1;
    check("code7 pulse", 64'(illegal_o), 64'd1);
    check("code7 popped", 64'(occ_o),    64'd0);

    // Two entries resident, then 10 cycles of simultaneous push and pop.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd0, 64'(100 + i), 8'h00);
      exp_q.push_back(64'(100 + i));
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd0, 64'(102 + i), 8'h01);
      exp_q.push_back(64'(102 + i));
      #1;
      exp_maj = exp_q.pop_front();
      check($sformatf("wrap%0d occ", i), 64'(occ_o), 64'd2);
      check($sformatf("wrap%0d maj", i), maj_o, exp_maj);
      @(negedge clk);
    end
    #1;
    check("wrap occ after", 64'(occ_o), 64'd2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'd0, 64'd0, 8'h01);
      #1;
      exp_maj = exp_q.pop_front();
      check($sformatf("wrap drain%0d", i), maj_o, exp_maj);
      @(negedge clk);
    end

    // Full payload pass-through on the branch unit.
    drive(1'b1, 3'd6, 64'h1234_5678_9ABC_DEF0, 8'h00);
    address_i = 64'hDEAD_BEEF_0123_4567; min_i = 7'h55; is64_i = 1'b1;
    pid_i = 20'hABCDE; tid_i = 16'h1357; op1_i = 5'd1; op2_i = 5'd30;
    op3_i = 5'd17; op4_i = 5'd9; imm_i = 64'hFFFF_0000_AAAA_5555;
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00);
    #1;
    check("pl valid",   64'(valid_o), 64'h40);
    check("pl unit",    64'(unit_o),  64'd6);
    check("pl maj",     maj_o,        64'h1234_5678_9ABC_DEF0);
    check("pl address", address_o,    64'hDEAD_BEEF_0123_4567);
    check("pl min",     64'(min_o),   64'h55);
    check("pl is64",    64'(is64_o),  64'd1);
    check("pl pid",     64'(pid_o),   64'hABCDE);
    check("pl tid",     64'(tid_o),   64'h1357);
    check("pl ops",     64'({op1_o, op2_o, op3_o, op4_o}), 64'({5'd1, 5'd30, 5'd17, 5'd9}));
    check("pl imm",     imm_o,        64'hFFFF_0000_AAAA_5555);

    // Reset with 3 entries queued and overflow set; enable during reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd0, 64'(50 + i), 8'h00);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 64'd0, 8'h01);
    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 8'h00);
    #1;
    check("pre-reset occ", 64'(occ_o),      64'd3);
    check("pre-reset ovf", 64'(overflow_o), 64'd1);
    reset_i = 1'b1;
    drive(1'b1, 3'd0, 64'd77, 8'h00);
    @(negedge clk);
    reset_i = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 8'h00);
    #1;
    check("rst occ",    64'(occ_o),      64'd0);
    check("rst ovf",    64'(overflow_o), 64'd0);
    check("rst stall",  64'(stall_o),    64'd0);
    check("rst valid",  64'(valid_o),    64'd0);
    check("rst maj",    maj_o,           64'd0);
    check("rst opcode", 64'(opcode_o),   64'd0);
    check("rst ill",    64'(illegal_o),  64'd0);
    @(negedge clk);
    #1;
    check("rst push ignored", 64'(occ_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
